// File: rtl/ysyx_22050854_pkg.sv
// Shared encodings for the ID/EX pipeline slice.
//   src1_sel_e : operand-1 source (rs1 / pc / zero, 11 also reads as zero)
//   src2_sel_e : operand-2 source (rs2 / immediate)
//   alu_ext_e  : result-extension codes carried through to execute
package ysyx_22050854_pkg;

  typedef enum logic [1:0] {
    SRC1_RS1  = 2'b00,
    SRC1_PC   = 2'b01,
    SRC1_ZERO = 2'b10,
    SRC1_RSVD = 2'b11
  } src1_sel_e;

  typedef enum logic {
    SRC2_RS2 = 1'b0,
    SRC2_IMM = 1'b1
  } src2_sel_e;

  typedef enum logic [2:0] {
    ALUEXT_NONE   = 3'd0,
    ALUEXT_SEXT_W = 3'd1,
    ALUEXT_ZEXT_W = 3'd2,
    ALUEXT_SEXT_H = 3'd3,
    ALUEXT_ZEXT_H = 3'd4,
    ALUEXT_SEXT_B = 3'd5,
    ALUEXT_ZEXT_B = 3'd6
  } alu_ext_e;

endpackage

// File: rtl/ysyx_22050854_id_ex_stage_if.sv
// Bundle of every non-clock signal between decode, the ID/EX slice,
// the forwarding sources and execute.
//   master : the surrounding pipeline (drives decode payload, forwarding,
//            flush, out_ready; observes the slice outputs)
//   slave  : the ID/EX slice itself
interface ysyx_22050854_id_ex_stage_if #(
  parameter int XLEN = 64,
  parameter int RA_W = 5
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_imm;
  logic [RA_W-1:0] id_rs1;
  logic [RA_W-1:0] id_rs2;
  logic [XLEN-1:0] id_rs1_data;
  logic [XLEN-1:0] id_rs2_data;
  logic [1:0]      id_src1_sel;
  logic            id_src2_sel;
  logic [3:0]      id_ALUctr;
  logic [3:0]      id_MULctr;
  logic [2:0]      id_ALUext;
  logic [RA_W-1:0] id_rd;
  logic            id_rd_wen;
  logic            id_mem_ren;
  logic            id_mem_wen;

  logic [RA_W-1:0] exm_rd;
  logic            exm_wen;
  logic            exm_is_load;
  logic [XLEN-1:0] exm_data;
  logic [RA_W-1:0] mwb_rd;
  logic            mwb_wen;
  logic [XLEN-1:0] mwb_data;

  logic            flush;

  logic            out_valid;
  logic            out_ready;
  logic [3:0]      ex_ALUctr;
  logic [3:0]      ex_MULctr;
  logic [2:0]      ex_ALUext;
  logic [XLEN-1:0] ex_src1;
  logic [XLEN-1:0] ex_src2;
  logic [XLEN-1:0] ex_store_data;
  logic [XLEN-1:0] ex_pc;
  logic [RA_W-1:0] ex_rd;
  logic            ex_rd_wen;
  logic            ex_mem_ren;
  logic            ex_mem_wen;
  logic            load_use_stall;
  logic [31:0]     stall_cnt;

  modport master (
    output in_valid, id_pc, id_imm, id_rs1, id_rs2, id_rs1_data, id_rs2_data,
           id_src1_sel, id_src2_sel, id_ALUctr, id_MULctr, id_ALUext,
           id_rd, id_rd_wen, id_mem_ren, id_mem_wen,
           exm_rd, exm_wen, exm_is_load, exm_data, mwb_rd, mwb_wen, mwb_data,
           flush, out_ready,
    input  in_ready, out_valid, ex_ALUctr, ex_MULctr, ex_ALUext, ex_src1,
           ex_src2, ex_store_data, ex_pc, ex_rd, ex_rd_wen, ex_mem_ren,
           ex_mem_wen, load_use_stall, stall_cnt
  );

  modport slave (
    input  in_valid, id_pc, id_imm, id_rs1, id_rs2, id_rs1_data, id_rs2_data,
           id_src1_sel, id_src2_sel, id_ALUctr, id_MULctr, id_ALUext,
           id_rd, id_rd_wen, id_mem_ren, id_mem_wen,
           exm_rd, exm_wen, exm_is_load, exm_data, mwb_rd, mwb_wen, mwb_data,
           flush, out_ready,
    output in_ready, out_valid, ex_ALUctr, ex_MULctr, ex_ALUext, ex_src1,
           ex_src2, ex_store_data, ex_pc, ex_rd, ex_rd_wen, ex_mem_ren,
           ex_mem_wen, load_use_stall, stall_cnt
  );
endinterface

// File: rtl/ysyx_22050854_fwd_mux.sv
// Resolves one source register value with bypassing.
//   rs, rf_data           : register index and regfile read data
//   exm_rd/wen/data       : producer one stage ahead (highest priority)
//   mwb_rd/wen/data       : producer two stages ahead
//   data                  : resolved value (x0 always reads as zero)
module ysyx_22050854_fwd_mux #(
  parameter int XLEN = 64,
  parameter int RA_W = 5
) (
  input  logic [RA_W-1:0] rs,
  input  logic [XLEN-1:0] rf_data,
  input  logic [RA_W-1:0] exm_rd,
  input  logic            exm_wen,
  input  logic [XLEN-1:0] exm_data,
  input  logic [RA_W-1:0] mwb_rd,
  input  logic            mwb_wen,
  input  logic [XLEN-1:0] mwb_data,
  output logic [XLEN-1:0] data
);

  // The younger producer wins because it holds the newest value of rs.
  always_comb begin
    data = rf_data;
    if (rs == '0) begin
      data = '0;
    end else if (exm_wen && (exm_rd == rs)) begin
      data = exm_data;
    end else if (mwb_wen && (mwb_rd == rs)) begin
      data = mwb_data;
    end
  end

endmodule

// File: rtl/ysyx_22050854_id_ex_stage.sv
// ID/EX pipeline register slice: one-entry valid/ready buffer that resolves
// operands with forwarding, detects load-use hazards and counts stall cycles.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : slave view of the decode/forwarding/execute bundle
module ysyx_22050854_id_ex_stage
  import ysyx_22050854_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int RA_W = 5
) (
  input logic clk,
  input logic rst_n,
  ysyx_22050854_id_ex_stage_if.slave bus
);

  logic [XLEN-1:0] rs1_val, rs2_val, src1_val, src2_val;
  logic            rs1_used, rs2_used, hazard, capture;

  logic            valid_q;
  logic [3:0]      alu_ctr_q, mul_ctr_q;
  logic [2:0]      alu_ext_q;
  logic [XLEN-1:0] src1_q, src2_q, store_q, pc_q;
  logic [RA_W-1:0] rd_q;
  logic            rd_wen_q, mem_ren_q, mem_wen_q;
  logic [31:0]     stall_cnt_q;

  ysyx_22050854_fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs1 (
    .rs(bus.id_rs1), .rf_data(bus.id_rs1_data),
    .exm_rd(bus.exm_rd), .exm_wen(bus.exm_wen), .exm_data(bus.exm_data),
    .mwb_rd(bus.mwb_rd), .mwb_wen(bus.mwb_wen), .mwb_data(bus.mwb_data),
    .data(rs1_val)
  );

  ysyx_22050854_fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs2 (
    .rs(bus.id_rs2), .rf_data(bus.id_rs2_data),
    .exm_rd(bus.exm_rd), .exm_wen(bus.exm_wen), .exm_data(bus.exm_data),
    .mwb_rd(bus.mwb_rd), .mwb_wen(bus.mwb_wen), .mwb_data(bus.mwb_data),
    .data(rs2_val)
  );

  // A load one stage ahead cannot forward yet; stores read rs2 even when
  // operand 2 is the immediate, so they count as rs2 users too.
  always_comb begin
    rs1_used = (bus.id_src1_sel == SRC1_RS1);
    rs2_used = (bus.id_src2_sel == SRC2_RS2) || bus.id_mem_wen;
    hazard   = bus.in_valid && bus.exm_wen && bus.exm_is_load &&
               (bus.exm_rd != '0) &&
               ((rs1_used && (bus.exm_rd == bus.id_rs1)) ||
                (rs2_used && (bus.exm_rd == bus.id_rs2)));
    capture  = bus.in_valid && bus.in_ready;
  end

  always_comb begin
    case (src1_sel_e'(bus.id_src1_sel))
      SRC1_RS1: src1_val = rs1_val;
      SRC1_PC:  src1_val = bus.id_pc;
      default:  src1_val = '0;
    endcase
    src2_val = (bus.id_src2_sel == SRC2_IMM) ? bus.id_imm : rs2_val;
  end

  assign bus.in_ready       = (!valid_q || bus.out_ready) && !hazard && !bus.flush;
  assign bus.load_use_stall = hazard;

  // Flush has top priority; the payload registers only move on a capture so
  // the outputs stay frozen while execute back-pressures.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      alu_ctr_q <= '0;
      mul_ctr_q <= '0;
      alu_ext_q <= '0;
      src1_q    <= '0;
      src2_q    <= '0;
      store_q   <= '0;
      pc_q      <= '0;
      rd_q      <= '0;
      rd_wen_q  <= 1'b0;
      mem_ren_q <= 1'b0;
      mem_wen_q <= 1'b0;
    end else if (bus.flush) begin
      valid_q <= 1'b0;
    end else if (capture) begin
      valid_q   <= 1'b1;
      alu_ctr_q <= bus.id_ALUctr;
      mul_ctr_q <= bus.id_MULctr;
      alu_ext_q <= bus.id_ALUext;
      src1_q    <= src1_val;
      src2_q    <= src2_val;
      store_q   <= rs2_val;
      pc_q      <= bus.id_pc;
      rd_q      <= bus.id_rd;
      rd_wen_q  <= bus.id_rd_wen;
      mem_ren_q <= bus.id_mem_ren;
      mem_wen_q <= bus.id_mem_wen;
    end else if (bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (hazard) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  // Side-effect controls are masked so a bubble can never write state.
  assign bus.out_valid     = valid_q;
  assign bus.ex_ALUctr     = alu_ctr_q;
  assign bus.ex_MULctr     = mul_ctr_q;
  assign bus.ex_ALUext     = alu_ext_q;
  assign bus.ex_src1       = src1_q;
  assign bus.ex_src2       = src2_q;
  assign bus.ex_store_data = store_q;
  assign bus.ex_pc         = pc_q;
  assign bus.ex_rd         = rd_q;
  assign bus.ex_rd_wen     = valid_q && rd_wen_q;
  assign bus.ex_mem_ren    = valid_q && mem_ren_q;
  assign bus.ex_mem_wen    = valid_q && mem_wen_q;
  assign bus.stall_cnt     = stall_cnt_q;

endmodule
